// File: rtl/fft_frame_buffer.sv
// ---------------------------------------------------------------------------
// fft_frame_buffer
//
// Producer end of the FFT -> display path. Captures one streamed FFT frame
// into a ping-pong RAM, keeping only bins 0..N/2-1 because a real-input
// spectrum is symmetric. A completed frame becomes visible to the reader
// through a bank swap, which is announced by a single-cycle `done` pulse.
// The reader presents FFT_addr and gets the bin back one cycle later.
//
// Input stream handshake: there is no back-pressure. A sample is
// transferred on every rising FFT_clk edge where in_valid is high.
// in_sop and in_eop are meaningful only on those edges.
//
// Ports
//   FFT_clk     sole clock, rising edge
//   rst         asynchronous active-low reset
//   in_valid    input sample valid
//   in_sop      start of frame (qualified by in_valid)
//   in_eop      end of frame (qualified by in_valid)
//   in_data_r   FFT real output sample
//   in_data_i   FFT imaginary output sample
//   rd_busy     reader mid-scan; a finished frame waits for it to drop
//   FFT_addr    bin index requested by the reader
//   FFT_data_r  bin real part, registered, 1-cycle latency
//   FFT_data_i  bin imaginary part, registered, 1-cycle latency
//   done        1-cycle pulse: a new frame is visible to the reader
//   frame_err   sticky malformed-frame flag, cleared only by rst
//   drop_cnt    frames dropped while a swap was pending, saturates at 255
//   FFT_mag     (FFT_MAG_EN only) |re|+|im| of the read bin, 2-cycle latency
//   fsm_state   current capture FSM state (0 idle, 1 capture, 2 pending)
//
// Optional feature: define FFT_MAG_EN to add the FFT_mag output.
// ---------------------------------------------------------------------------
module fft_frame_buffer #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  FFT_clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [DATA_WIDTH-1:0] in_data_r,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  rd_busy,
    input  logic [ADDR_WIDTH-2:0] FFT_addr,
    output logic [DATA_WIDTH-1:0] FFT_data_r,
    output logic [DATA_WIDTH-1:0] FFT_data_i,
    output logic                  done,
    output logic                  frame_err,
    output logic [7:0]            drop_cnt,
`ifdef FFT_MAG_EN
    output logic [DATA_WIDTH:0]   FFT_mag,
`endif
    output logic [1:0]            fsm_state
);

    localparam int N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_PENDING = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;   // index of the sample presented now
    logic                    rd_bank;        // write bank is always the other one
    logic                    swap;
    logic                    err_set;
    logic                    drop_inc;
    logic                    wr_en;
    logic [ADDR_WIDTH-2:0]   wr_addr;

    // Both banks in one array; the bank bit is the address MSB.
    logic [2*DATA_WIDTH-1:0] mem [0:N-1];

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        swap      = 1'b0;
        err_set   = 1'b0;
        drop_inc  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = cnt[ADDR_WIDTH-2:0];

        case (state)
            S_IDLE: begin
                if (in_valid && in_sop) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    cnt_nxt   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    state_nxt = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                if (in_valid) begin
                    if (in_eop) begin
                        // Upper half (cnt MSB set) is the mirrored spectrum.
                        wr_en   = ~cnt[ADDR_WIDTH-1];
                        cnt_nxt = '0;
                        if (cnt == LAST_IDX) begin
                            if (!rd_busy) begin
                                swap      = 1'b1;
                                state_nxt = S_IDLE;
                            end else begin
                                state_nxt = S_PENDING;
                            end
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = S_IDLE;
                        end
                    end else if (in_sop && cnt != '0) begin
                        // Early sop: this sample becomes index 0 of a new frame.
                        err_set = 1'b1;
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        cnt_nxt = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end else if (cnt == LAST_IDX) begin
                        // Last index reached without eop.
                        err_set   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        wr_en   = ~cnt[ADDR_WIDTH-1];
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            S_PENDING: begin
                // No writes here: the write bank holds the finished frame.
                if (in_valid && in_sop) begin
                    drop_inc = 1'b1;
                end
                if (!rd_busy) begin
                    swap      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge FFT_clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rd_bank   <= 1'b1;
            done      <= 1'b0;
            frame_err <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rd_bank <= rd_bank ^ swap;
            done    <= swap;
            if (err_set) begin
                frame_err <= 1'b1;
            end
            if (drop_inc && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Ping-pong RAM: write port into the write bank only
    // ------------------------------------------------------------------
    always_ff @(posedge FFT_clk) begin
        if (wr_en) begin
            mem[{~rd_bank, wr_addr}] <= {in_data_r, in_data_i};
        end
    end

    // Read port. rd_bank is sampled at the same edge as FFT_addr, so a swap
    // on that edge still returns data from the old bank.
    always_ff @(posedge FFT_clk or negedge rst) begin
        if (!rst) begin
            FFT_data_r <= '0;
            FFT_data_i <= '0;
        end else begin
            {FFT_data_r, FFT_data_i} <= mem[{rd_bank, FFT_addr}];
        end
    end

`ifdef FFT_MAG_EN
    // Two's-complement magnitude; the most negative value has no positive
    // counterpart so it clamps to the largest positive value.
    function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic [DATA_WIDTH-1:0] v);
        if (!v[DATA_WIDTH-1]) begin
            return v;
        end else if (v == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            return -v;
        end
    endfunction

    always_ff @(posedge FFT_clk or negedge rst) begin
        if (!rst) begin
            FFT_mag <= '0;
        end else begin
            FFT_mag <= {1'b0, sat_abs(FFT_data_r)} + {1'b0, sat_abs(FFT_data_i)};
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_buffer.sv
module tb_fft_frame_buffer;

    localparam int DW = 18;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_sop;
    logic          in_eop;
    logic [DW-1:0] in_data_r;
    logic [DW-1:0] in_data_i;
    logic          rd_busy;
    logic [AW-2:0] FFT_addr;
    logic [DW-1:0] FFT_data_r;
    logic [DW-1:0] FFT_data_i;
    logic          done;
    logic          frame_err;
    logic [7:0]    drop_cnt;
    logic [1:0]    fsm_state;
`ifdef FFT_MAG_EN
    logic [DW:0]   FFT_mag;
`endif

    int total = 0;
    int bad   = 0;
    int done_cnt  = 0;
    int done_wide = 0;
    int exp_done  = 0;
    logic done_prev = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fft_frame_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .FFT_clk   (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_data_r (in_data_r),
        .in_data_i (in_data_i),
        .rd_busy   (rd_busy),
        .FFT_addr  (FFT_addr),
        .FFT_data_r(FFT_data_r),
        .FFT_data_i(FFT_data_i),
        .done      (done),
        .frame_err (frame_err),
        .drop_cnt  (drop_cnt),
`ifdef FFT_MAG_EN
        .FFT_mag   (FFT_mag),
`endif
        .fsm_state (fsm_state)
    );

    // done pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (done === 1'b1 && done_prev === 1'b1) done_wide++;
        done_prev = done;
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DW-1:0] to_dw(input int v);
        return v[DW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sop, input bit eop, input int r, input int i);
        in_valid  = 1'b1;
        in_sop    = sop;
        in_eop    = eop;
        in_data_r = to_dw(r);
        in_data_i = to_dw(i);
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // samples k=0..eop_at, r=k+off, i=-(k+off), sop on 0, eop on eop_at
    task automatic send_frame(input int off, input int eop_at);
        for (int k = 0; k <= eop_at; k++) begin
            send(k == 0, k == eop_at, k + off, -(k + off));
        end
    endtask

    task automatic do_read(input int addr, output logic [DW-1:0] r, output logic [DW-1:0] i);
        FFT_addr = addr[AW-2:0];
        tick();
        r = FFT_data_r;
        i = FFT_data_i;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        in_data_r = '0; in_data_i = '0; rd_busy = 1'b0; FFT_addr = '0;
        tick(); tick();
        total++; if (FFT_data_r !== '0) begin bad++; $display("FAIL rst_data_r got=%0h exp=0", FFT_data_r); end
        total++; if (FFT_data_i !== '0) begin bad++; $display("FAIL rst_data_i got=%0h exp=0", FFT_data_i); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", frame_err); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rst_drop got=%0d exp=0", drop_cnt); end
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", fsm_state); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        logic [DW-1:0] r, i;
        rd_busy = 1'b0;
        send_frame(0, 511);
        exp_done++;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL good_done got=%b exp=1", done); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL good_done_width got=%b exp=0", done); end
        do_read(5, r, i);
        total++; if (r !== to_dw(5)) begin bad++; $display("FAIL good_r5 got=%0h exp=%0h", r, to_dw(5)); end
        total++; if (i !== to_dw(-5)) begin bad++; $display("FAIL good_i5 got=%0h exp=%0h", i, to_dw(-5)); end
        do_read(255, r, i);
        total++; if (r !== to_dw(255)) begin bad++; $display("FAIL good_r255 got=%0h exp=%0h", r, to_dw(255)); end
        total++; if (i !== to_dw(-255)) begin bad++; $display("FAIL good_i255 got=%0h exp=%0h", i, to_dw(-255)); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL good_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_busy_swap();
        logic [DW-1:0] r, i;
        int d0;
        rd_busy = 1'b1;
        send_frame(1000, 511);
        d0 = done_cnt;
        total++; if (fsm_state !== 2'd2) begin bad++; $display("FAIL busy_state got=%0d exp=2", fsm_state); end
        for (int c = 0; c < 39; c++) tick();
        do_read(5, r, i);
        total++; if (r !== to_dw(5)) begin bad++; $display("FAIL busy_old_r5 got=%0h exp=%0h", r, to_dw(5)); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL busy_no_done got=%0d exp=%0d", done_cnt, d0); end
        rd_busy = 1'b0;
        tick();
        exp_done++;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_release_done got=%b exp=1", done); end
        do_read(5, r, i);
        total++; if (r !== to_dw(1005)) begin bad++; $display("FAIL busy_new_r5 got=%0h exp=%0h", r, to_dw(1005)); end
        total++; if (i !== to_dw(-1005)) begin bad++; $display("FAIL busy_new_i5 got=%0h exp=%0h", i, to_dw(-1005)); end
    endtask

    task automatic test_drop();
        logic [DW-1:0] r, i;
        rd_busy = 1'b1;
        send_frame(2000, 511);
        send(1'b1, 1'b0, 7777, 7777);
        for (int k = 1; k < 10; k++) send(1'b0, k == 9, 7777 + k, 0);
        total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL drop_one got=%0d exp=1", drop_cnt); end
        do_read(5, r, i);
        total++; if (r !== to_dw(1005)) begin bad++; $display("FAIL drop_bank_r5 got=%0h exp=%0h", r, to_dw(1005)); end
        for (int k = 0; k < 256; k++) send(1'b1, 1'b0, k, k);
        total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
        rd_busy = 1'b0;
        tick();
        exp_done++;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL drop_release_done got=%b exp=1", done); end
        do_read(5, r, i);
        total++; if (r !== to_dw(2005)) begin bad++; $display("FAIL drop_new_r5 got=%0h exp=%0h", r, to_dw(2005)); end
    endtask

    task automatic test_short_eop();
        logic [DW-1:0] r, i;
        int d0;
        rd_busy = 1'b0;
        d0 = done_cnt;
        send_frame(3000, 300);
        tick(); tick();
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL short_err got=%b exp=1", frame_err); end
        total++; if (done_cnt !== d0) begin bad++; $display("FAIL short_no_done got=%0d exp=%0d", done_cnt, d0); end
        do_read(5, r, i);
        total++; if (r !== to_dw(2005)) begin bad++; $display("FAIL short_prior_r5 got=%0h exp=%0h", r, to_dw(2005)); end
        send_frame(4000, 511);
        exp_done++;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL short_next_done got=%b exp=1", done); end
        do_read(255, r, i);
        total++; if (r !== to_dw(4255)) begin bad++; $display("FAIL short_next_r255 got=%0h exp=%0h", r, to_dw(4255)); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] r, i;
        for (int k = 0; k < 100; k++) send(k == 0, 1'b0, 5000 + k, 0);
        in_valid = 1'b1; in_data_r = to_dw(5100);
        #2;
        rst = 1'b0;
        #1;
        total++; if (FFT_data_r !== '0) begin bad++; $display("FAIL mid_rst_data_r got=%0h exp=0", FFT_data_r); end
        total++; if (FFT_data_i !== '0) begin bad++; $display("FAIL mid_rst_data_i got=%0h exp=0", FFT_data_i); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b exp=0", frame_err); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_drop got=%0d exp=0", drop_cnt); end
        total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL mid_rst_state got=%0d exp=0", fsm_state); end
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        send_frame(6000, 511);
        exp_done++;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL post_rst_done got=%b exp=1", done); end
        do_read(5, r, i);
        total++; if (r !== to_dw(6005)) begin bad++; $display("FAIL post_rst_r5 got=%0h exp=%0h", r, to_dw(6005)); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL post_rst_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_sop_restart();
        logic [DW-1:0] r, i;
        for (int k = 0; k < 50; k++) send(k == 0, 1'b0, 9000 + k, 0);
        send_frame(7000, 511);
        exp_done++;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done got=%b exp=1", done); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL restart_err got=%b exp=1", frame_err); end
        do_read(0, r, i);
        total++; if (r !== to_dw(7000)) begin bad++; $display("FAIL restart_r0 got=%0h exp=%0h", r, to_dw(7000)); end
        do_read(200, r, i);
        total++; if (i !== to_dw(-7200)) begin bad++; $display("FAIL restart_i200 got=%0h exp=%0h", i, to_dw(-7200)); end
    endtask

`ifdef FFT_MAG_EN
    task automatic test_mag();
        for (int k = 0; k < 512; k++) begin
            if (k == 7)      send(1'b0, 1'b0, -3, 4);
            else if (k == 8) send(1'b0, 1'b0, -131072, 0);
            else             send(k == 0, k == 511, k, -k);
        end
        exp_done++;
        FFT_addr = 7'd7;
        tick(); tick();
        total++; if (FFT_mag !== 19'd7) begin bad++; $display("FAIL mag_7 got=%0d exp=7", FFT_mag); end
        FFT_addr = 7'd8;
        tick(); tick();
        total++; if (FFT_mag !== 19'd131071) begin bad++; $display("FAIL mag_sat got=%0d exp=131071", FFT_mag); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_busy_swap();
        test_drop();
        test_short_eop();
        test_reset_mid();
        test_sop_restart();
`ifdef FFT_MAG_EN
        test_mag();
`endif
        tick(); tick();
        total++; if (done_cnt !== exp_done) begin bad++; $display("FAIL done_count got=%0d exp=%0d", done_cnt, exp_done); end
        total++; if (done_wide !== 0) begin bad++; $display("FAIL done_pulse_width got=%0d exp=0", done_wide); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
